// File: rtl/queue_pkg.sv
// Shared types, default sizes and helpers for the bit-granular queue.
package queue_pkg;

  typedef logic [31:0] count_t;

  localparam int unsigned InWidthDef  = 512;
  localparam int unsigned OutWidthDef = 120;
  localparam int unsigned CapacityDef = 2048;

  // Pointer width for a power-of-two capacity.
  function automatic int unsigned clog2_cap(input int unsigned cap);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < cap) w++;
    return w;
  endfunction

endpackage

// File: rtl/queue_rot.sv
// Barrel rotator over a WIDTH-bit left-aligned vector: dout[i] = din[(amt + i) mod WIDTH].
module queue_rot #(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned AMT_W = 11,
  parameter int unsigned OUT_W = 2048
) (
  input  logic [0:WIDTH-1] din,
  input  logic [AMT_W-1:0] amt,
  output logic [0:OUT_W-1] dout
);

  logic [0:2*WIDTH-1] dbl;

  assign dbl  = {din, din};
  assign dout = dbl[amt +: OUT_W];

endmodule

// File: rtl/queue.sv
// Bit-granular FIFO: variable-length enqueue, fixed zero-padded head window.
// Optional runtime checks for dropped transfers and out-of-range counts: QUEUE_CHECK_EN.
module queue
  import queue_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = InWidthDef,
  parameter int unsigned OUT_WIDTH = OutWidthDef,
  parameter int unsigned CAPACITY  = CapacityDef
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_en,
  input  logic [31:0]          enq_cnt,
  input  logic [0:IN_WIDTH-1]  enq_data,
  input  logic                 deq_en,
  input  logic [31:0]          deq_cnt,
  output logic [0:OUT_WIDTH-1] deq_data,
  output logic [31:0]          used_cnt,
  output logic [31:0]          empty_cnt
);

  localparam int unsigned PtrW = clog2_cap(CAPACITY);

  logic [0:CAPACITY-1]  store_q, store_d;
  logic [0:CAPACITY-1]  data_ext, mask_ext, data_rot, mask_rot;
  logic [0:OUT_WIDTH-1] win_rot;
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d, wr_amt;
  count_t               used_q, used_d, empty;
  logic                 enq_ok, deq_ok;

  assign empty  = count_t'(CAPACITY) - used_q;
  assign enq_ok = enq_en && (enq_cnt <= empty);
  assign deq_ok = deq_en && (deq_cnt <= used_q);

  // Build the left-aligned chunk and its valid mask before rotating onto the tail.
  always_comb begin
    data_ext = '0;
    mask_ext = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      mask_ext[i] = count_t'(i) < enq_cnt;
      data_ext[i] = enq_data[i] & mask_ext[i];
    end
  end

  // Rotating by -tail places chunk bit 0 at storage index tail.
  assign wr_amt = '0 - tail_q;

  queue_rot #(.WIDTH(CAPACITY), .AMT_W(PtrW), .OUT_W(CAPACITY)) u_rot_data (
    .din  (data_ext),
    .amt  (wr_amt),
    .dout (data_rot)
  );

  queue_rot #(.WIDTH(CAPACITY), .AMT_W(PtrW), .OUT_W(CAPACITY)) u_rot_mask (
    .din  (mask_ext),
    .amt  (wr_amt),
    .dout (mask_rot)
  );

  queue_rot #(.WIDTH(CAPACITY), .AMT_W(PtrW), .OUT_W(OUT_WIDTH)) u_rot_win (
    .din  (store_q),
    .amt  (head_q),
    .dout (win_rot)
  );

  always_comb begin
    store_d = store_q;
    tail_d  = tail_q;
    head_d  = head_q;
    used_d  = used_q;
    if (enq_ok) begin
      store_d = (store_q & ~mask_rot) | data_rot;
      tail_d  = tail_q + enq_cnt[PtrW-1:0];
      used_d  = used_d + enq_cnt;
    end
    if (deq_ok) begin
      head_d = head_q + deq_cnt[PtrW-1:0];
      used_d = used_d - deq_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      used_q  <= '0;
    end else begin
      store_q <= store_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      used_q  <= used_d;
    end
  end

  // Bits past the occupancy are stale storage and must read as zero.
  always_comb begin
    deq_data = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      deq_data[i] = win_rot[i] & (count_t'(i) < used_q);
    end
  end

  assign used_cnt  = used_q;
  assign empty_cnt = empty;

`ifdef QUEUE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (enq_en && (enq_cnt != '0) && !enq_ok) begin
        $display("%m: enqueue overflow dropped, enq_cnt=%0d used_cnt=%0d", enq_cnt, used_q);
      end
      if (deq_en && (deq_cnt != '0) && !deq_ok) begin
        $display("%m: dequeue underflow dropped, deq_cnt=%0d used_cnt=%0d", deq_cnt, used_q);
      end
      assert (!(enq_en && (enq_cnt > count_t'(IN_WIDTH))))
        else $error("%m: enq_cnt=%0d exceeds IN_WIDTH", enq_cnt);
      assert (!(deq_en && (deq_cnt > count_t'(OUT_WIDTH))))
        else $error("%m: deq_cnt=%0d exceeds OUT_WIDTH", deq_cnt);
    end
  end
`else
  // Checks compiled out; datapath is unaffected.
`endif

endmodule

// File: tb/tb_queue.sv
// Directed self-checking bench for the bit-granular queue.
module tb_queue;

  localparam int IW  = 512;
  localparam int OW  = 120;
  localparam int CAP = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_en;
  logic [31:0]   enq_cnt;
  logic [0:IW-1] enq_data;
  logic          deq_en;
  logic [31:0]   deq_cnt;
  logic [0:OW-1] deq_data;
  logic [31:0]   used_cnt;
  logic [31:0]   empty_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:IW-1] ones;
  logic [0:IW-1] c0;

  always #5 clk = ~clk;

  queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CAPACITY(CAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_en    (enq_en),
    .enq_cnt   (enq_cnt),
    .enq_data  (enq_data),
    .deq_en    (deq_en),
    .deq_cnt   (deq_cnt),
    .deq_data  (deq_data),
    .used_cnt  (used_cnt),
    .empty_cnt (empty_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    enq_en = 1'b0;
    deq_en = 1'b0;
  endtask

  task automatic enq(input int cnt, input logic [0:IW-1] d);
    enq_en   = 1'b1;
    enq_cnt  = cnt;
    enq_data = d;
    cyc();
  endtask

  task automatic deq(input int cnt);
    deq_en  = 1'b1;
    deq_cnt = cnt;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ones     = '1;
    c0       = {144'h000102030405060708090A0B0C0D0E0F1011, 368'h0};
    reset    = 1'b0;
    enq_en   = 1'b0;
    enq_cnt  = '0;
    enq_data = '0;
    deq_en   = 1'b0;
    deq_cnt  = '0;
    #12;
    chk("reset_used", 128'(used_cnt), 128'(0));
    chk("reset_empty", 128'(empty_cnt), 128'(2048));
    chk("reset_win", 128'(deq_data), 128'(0));
    reset = 1'b1;

    // 64-bit enqueue; trailing ones beyond enq_cnt must be ignored.
    enq(64, {64'hA5A5A5A5A5A5A5A5, {448{1'b1}}});
    chk("enq64_used", 128'(used_cnt), 128'(64));
    chk("enq64_empty", 128'(empty_cnt), 128'(1984));
    chk("enq64_win", 128'(deq_data), 128'({64'hA5A5A5A5A5A5A5A5, 56'h0}));
    enq(0, ones);
    chk("enq0_used", 128'(used_cnt), 128'(64));
    deq(0);
    chk("deq0_used", 128'(used_cnt), 128'(64));
    chk("deq0_win", 128'(deq_data), 128'({64'hA5A5A5A5A5A5A5A5, 56'h0}));

    // Fill to capacity, then overflow.
    do_reset();
    enq(512, c0);
    enq(512, '0);
    enq(512, '0);
    enq(512, '0);
    chk("full_used", 128'(used_cnt), 128'(2048));
    chk("full_empty", 128'(empty_cnt), 128'(0));
    enq(8, ones);
    chk("ovf_used", 128'(used_cnt), 128'(2048));
    chk("ovf_win", 128'(deq_data), 128'(120'h000102030405060708090A0B0C0D0E));
    enq_en   = 1'b1;
    enq_cnt  = 8;
    enq_data = ones;
    deq_en   = 1'b1;
    deq_cnt  = 24;
    cyc();
    chk("fullsim_used", 128'(used_cnt), 128'(2024));
    chk("fullsim_empty", 128'(empty_cnt), 128'(24));
    chk("fullsim_win", 128'(deq_data), 128'(120'h030405060708090A0B0C0D0E0F1011));

    // Wrap-around: tail 2040, head 2000, then a 64-bit write across the end.
    do_reset();
    enq(512, ones);
    enq(512, ones);
    enq(512, ones);
    enq(504, ones);
    chk("wrap_fill", 128'(used_cnt), 128'(2040));
    for (int k = 0; k < 16; k++) deq(120);
    deq(80);
    chk("wrap_drain", 128'(used_cnt), 128'(40));
    enq(64, {64'h0123456789ABCDEF, {448{1'b1}}});
    chk("wrap_used", 128'(used_cnt), 128'(104));
    chk("wrap_win0", 128'(deq_data), 128'({40'hFFFFFFFFFF, 64'h0123456789ABCDEF, 16'h0}));
    deq(40);
    chk("wrap_win1", 128'(deq_data), 128'({64'h0123456789ABCDEF, 56'h0}));
    deq(64);
    chk("wrap_end_used", 128'(used_cnt), 128'(0));
    chk("wrap_end_win", 128'(deq_data), 128'(0));

    // Underflow is dropped whole.
    do_reset();
    enq(16, {16'hBEEF, {496{1'b1}}});
    deq(24);
    chk("udf_used", 128'(used_cnt), 128'(16));
    chk("udf_win", 128'(deq_data), 128'({16'hBEEF, 104'h0}));
    deq(16);
    chk("udf_drain_used", 128'(used_cnt), 128'(0));
    chk("udf_drain_win", 128'(deq_data), 128'(0));

    // Asynchronous reset mid-stream, checked before any clock edge.
    enq(500, ones);
    chk("mid_used", 128'(used_cnt), 128'(500));
    reset = 1'b0;
    #1;
    chk("arst_used", 128'(used_cnt), 128'(0));
    chk("arst_empty", 128'(empty_cnt), 128'(2048));
    chk("arst_win", 128'(deq_data), 128'(0));
    #1;
    reset = 1'b1;
    enq(8, {8'h5A, {504{1'b1}}});
    chk("post_used", 128'(used_cnt), 128'(8));
    chk("post_win", 128'(deq_data), 128'({8'h5A, 112'h0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
